// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer between fetch (up to 2 pushes/cycle) and dual-issue decode.
// Optional same-cycle empty-queue bypass enabled by defining INST_FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_valid,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_inst1,
    input  logic [31:0]              push_inst2,
    input  logic                     push_inst2_valid,
    input  logic [1:0]               pop_num,
    output logic                     out_valid1,
    output logic                     out_valid2,
    output logic [31:0]              out_pc1,
    output logic [31:0]              out_pc2,
    output logic [31:0]              out_inst1,
    output logic [31:0]              out_inst2,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic [AW-1:0] head, tail, head_p1, tail_p1;
    logic [CW-1:0] count_q;

    logic [1:0]    pop_req, pop_eff, push_w, wr_num;
    logic          push_ok;
    logic [31:0]   push_pc2;
    logic [31:0]   wr0_pc, wr0_inst, wr1_pc, wr1_inst;

    assign count    = count_q;
    assign full     = count_q >= CW'(DEPTH - 1);
    assign head_p1  = head + AW'(1);
    assign tail_p1  = tail + AW'(1);
    assign push_pc2 = push_pc + 32'd4;

    // A push while full is dropped whole; pop in the same cycle does not make room for it.
    assign push_ok  = push_valid && !full && !flush && !rst;

`ifdef INST_FETCH_QUEUE_BYPASS_EN
    logic       bypass;
    logic [1:0] byp_pop;
    assign bypass  = (count_q == '0) && push_valid && !flush && !rst;
`endif

    always_comb begin
        pop_req  = (pop_num == 2'd3) ? 2'd2 : pop_num;
        push_w   = push_inst2_valid ? 2'd2 : 2'd1;
        pop_eff  = (count_q >= CW'(pop_req)) ? pop_req : count_q[1:0];
        wr_num   = push_ok ? push_w : 2'd0;
        wr0_pc   = push_pc;
        wr0_inst = push_inst1;
        wr1_pc   = push_pc2;
        wr1_inst = push_inst2;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        byp_pop  = (pop_req < push_w) ? pop_req : push_w;
        // Instructions decode consumes straight from the bypass are never stored.
        if (bypass) begin
            wr_num = push_w - byp_pop;
            if (byp_pop == 2'd1) begin
                wr0_pc   = push_pc2;
                wr0_inst = push_inst2;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + AW'(pop_eff);
            tail    <= tail + AW'(wr_num);
            count_q <= count_q - CW'(pop_eff) + CW'(wr_num);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_num != 2'd0) begin
            mem_pc[tail]   <= wr0_pc;
            mem_inst[tail] <= wr0_inst;
        end
        if (wr_num == 2'd2) begin
            mem_pc[tail_p1]   <= wr1_pc;
            mem_inst[tail_p1] <= wr1_inst;
        end
    end

    always_comb begin
        out_valid1 = count_q != '0;
        out_valid2 = count_q >= CW'(2);
        out_pc1    = out_valid1 ? mem_pc[head]      : 32'd0;
        out_inst1  = out_valid1 ? mem_inst[head]    : 32'd0;
        out_pc2    = out_valid2 ? mem_pc[head_p1]   : 32'd0;
        out_inst2  = out_valid2 ? mem_inst[head_p1] : 32'd0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            out_valid1 = 1'b1;
            out_pc1    = push_pc;
            out_inst1  = push_inst1;
            out_valid2 = push_inst2_valid;
            out_pc2    = push_inst2_valid ? push_pc2   : 32'd0;
            out_inst2  = push_inst2_valid ? push_inst2 : 32'd0;
        end
`endif
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: driver pushes expected outputs, monitor compares each cycle.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, flush, push_valid, push_inst2_valid;
    logic [31:0]   push_pc, push_inst1, push_inst2;
    logic [1:0]    pop_num;
    logic          out_valid1, out_valid2, full;
    logic [31:0]   out_pc1, out_pc2, out_inst1, out_inst2;
    logic [CW-1:0] count;

    typedef struct packed {
        logic          v1;
        logic          v2;
        logic [31:0]   pc1;
        logic [31:0]   pc2;
        logic [31:0]   i1;
        logic [31:0]   i2;
        logic          full;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    exp_t exp_q[$];
    ent_t mq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   chk_en = 0;
    bit   done   = 0;
    logic [31:0] seq_pc;

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid),
        .push_pc(push_pc), .push_inst1(push_inst1), .push_inst2(push_inst2),
        .push_inst2_valid(push_inst2_valid), .pop_num(pop_num),
        .out_valid1(out_valid1), .out_valid2(out_valid2),
        .out_pc1(out_pc1), .out_pc2(out_pc2),
        .out_inst1(out_inst1), .out_inst2(out_inst2),
        .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step(input bit r, input bit f, input bit pv, input logic [31:0] pc,
                        input logic [31:0] i1, input logic [31:0] i2, input bit i2v,
                        input logic [1:0] pn);
        exp_t e;
        ent_t g[$];
        int   n, req, k;
        @(negedge clk);
        rst = r; flush = f; push_valid = pv; push_pc = pc;
        push_inst1 = i1; push_inst2 = i2; push_inst2_valid = i2v; pop_num = pn;
        n = mq.size();
        e.v1   = n >= 1;
        e.v2   = n >= 2;
        e.pc1  = (n >= 1) ? mq[0].pc   : 32'd0;
        e.i1   = (n >= 1) ? mq[0].inst : 32'd0;
        e.pc2  = (n >= 2) ? mq[1].pc   : 32'd0;
        e.i2   = (n >= 2) ? mq[1].inst : 32'd0;
        e.full = (DEPTH - n) < 2;
        e.cnt  = CW'(n);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        if (n == 0 && pv && !f && !r) begin
            e.v1 = 1'b1; e.pc1 = pc; e.i1 = i1;
            e.v2 = i2v;
            e.pc2 = i2v ? pc + 32'd4 : 32'd0;
            e.i2  = i2v ? i2 : 32'd0;
        end
`endif
        if (chk_en) exp_q.push_back(e);
        g.push_back('{pc, i1});
        if (i2v) g.push_back('{pc + 32'd4, i2});
        req = (pn == 2'd3) ? 2 : int'(pn);
        if (r || f) begin
            mq.delete();
        end else begin
`ifdef INST_FETCH_QUEUE_BYPASS_EN
            if (n == 0 && pv) begin
                k = (req < g.size()) ? req : g.size();
                repeat (k) void'(g.pop_front());
            end
`endif
            k = (req < n) ? req : n;
            repeat (k) void'(mq.pop_front());
            if (pv && (DEPTH - n) >= 2)
                foreach (g[j]) mq.push_back(g[j]);
        end
    endtask

    task automatic idle(input logic [1:0] pn);
        step(0, 0, 0, 32'd0, 32'd0, 32'd0, 0, pn);
    endtask

    task automatic push_pair(input logic [31:0] pc, input logic [1:0] pn);
        step(0, 0, 1, pc, pc ^ 32'hA5A5_0000, pc ^ 32'h5A5A_0004, 1, pn);
    endtask

    // Monitor: samples mid-low-phase, once the driver has settled the inputs.
    initial begin
        exp_t a, e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {out_valid1, out_valid2, out_pc1, out_pc2, out_inst1, out_inst2, full, count};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cyc %0d got v=%b%b pc=%h/%h inst=%h/%h full=%b cnt=%0d required v=%b%b pc=%h/%h inst=%h/%h full=%b cnt=%0d",
                             cyc, a.v1, a.v2, a.pc1, a.pc2, a.i1, a.i2, a.full, a.cnt,
                             e.v1, e.v2, e.pc1, e.pc2, e.i1, e.i2, e.full, e.cnt);
                end
            end
        end
    end

    initial begin
        rst = 1; flush = 0; push_valid = 0; push_pc = 0; push_inst1 = 0;
        push_inst2 = 0; push_inst2_valid = 0; pop_num = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        step(1, 0, 0, 0, 0, 0, 0, 0);

        push_pair(32'hBFC0_0000, 0);
        idle(0);

        for (int i = 0; i < 5; i++) push_pair(32'h1000_0000 + 32'(i * 8), 0);
        idle(0);
        for (int i = 0; i < 6; i++) idle(2);

        seq_pc = 32'h2000_0000;
        push_pair(seq_pc, 0);
        seq_pc += 8;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            push_pair(seq_pc, 2);
            seq_pc += 8;
        end
        idle(3);
        idle(0);

        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h3000_0000, 32'h1111_1111, 32'd0, 0, 0);
        idle(2);
        push_pair(32'h3000_0100, 0);
        idle(0);

        push_pair(32'h4000_0000, 0);
        push_pair(32'h4000_0008, 0);
        step(0, 0, 1, 32'h4000_0010, 32'h2222_2222, 32'd0, 0, 0);
        step(0, 1, 1, 32'h4000_0020, 32'h3333_3333, 32'h4444_4444, 1, 0);
        idle(0);

        step(0, 1, 0, 0, 0, 0, 0, 0);
        push_pair(32'h5000_0000, 2);
        idle(0);
        push_pair(32'hFFFF_FFFC, 1);
        idle(0);

        for (int i = 0; i < 400; i++) begin
            bit r, f, pv, i2v;
            r   = ($urandom_range(63) == 0);
            f   = ($urandom_range(31) == 0);
            pv  = ($urandom_range(3) != 0);
            i2v = $urandom_range(1);
            step(r, f, pv, {$urandom, 2'b00} , $urandom, $urandom, i2v,
                 2'($urandom_range(3)));
        end
        idle(0);

        @(negedge clk);
        #4;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
